// File: rtl/cpu_md_pkg.sv
// Shared op encodings, FSM states and iteration count for the multiply/divide unit.
package cpu_md_pkg;

   localparam int unsigned CALC_CYCLES = 32;

   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110,
      OP_RSVD  = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREP,
      ST_CALC,
      ST_FIX
   } md_state_e;

endpackage

// File: rtl/cpu_md_step.sv
// One iteration of the shift-add multiplier or the restoring divider.
// Multiply: hi = accumulator, lo = multiplier. Divide: hi = partial remainder, lo = dividend/quotient.
module cpu_md_step (
   input  logic        is_div,
   input  logic [31:0] opnd,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [32:0] trial;

   always_comb begin
      sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : 33'd0);
      shifted = {hi_in, lo_in[31]};
      trial   = shifted - {1'b0, opnd};
      hi_out  = '0;
      lo_out  = '0;
      if (is_div) begin
         // Partial remainder stays below the divisor, so a set bit 32 means the trial went negative.
         if (!trial[32]) begin
            hi_out = trial[31:0];
            lo_out = {lo_in[30:0], 1'b1};
         end else begin
            hi_out = shifted[31:0];
            lo_out = {lo_in[30:0], 1'b0};
         end
      end else begin
         hi_out = sum[32:1];
         lo_out = {sum[0], lo_in[31:1]};
      end
   end

endmodule

// File: rtl/cpu_muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO: accepts EX-stage ops, iterates 32 steps,
// applies the sign fix-up and stalls the pipeline while busy.
module cpu_muldiv_ctrl
   import cpu_md_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        md_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] md_src_a,
   input  logic [31:0] md_src_b,
   input  logic        md_flush,
   input  logic        mf_req,
   output logic        md_stall,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e   state;
   logic [4:0]  cnt;
   logic        is_div;
   logic        is_signed;
   logic        q_neg;
   logic        r_neg;
   logic [31:0] a_raw;
   logic [31:0] b_raw;
   logic [31:0] opnd;
   logic [31:0] hi_w;
   logic [31:0] lo_w;
   logic [31:0] step_hi;
   logic [31:0] step_lo;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [63:0] prod;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign md_stall = md_busy & (md_valid | mf_req);

   assign abs_a    = (is_signed && a_raw[31]) ? (~a_raw + 32'd1) : a_raw;
   assign abs_b    = (is_signed && b_raw[31]) ? (~b_raw + 32'd1) : b_raw;
   assign prod     = {hi_w, lo_w};
   assign prod_fix = q_neg ? (~prod + 64'd1) : prod;
   assign quo_fix  = q_neg ? (~lo_w + 32'd1) : lo_w;
   assign rem_fix  = r_neg ? (~hi_w + 32'd1) : hi_w;

   cpu_md_step u_step (
      .is_div (is_div),
      .opnd   (opnd),
      .hi_in  (hi_w),
      .lo_in  (lo_w),
      .hi_out (step_hi),
      .lo_out (step_lo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         is_div    <= 1'b0;
         is_signed <= 1'b0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         a_raw     <= '0;
         b_raw     <= '0;
         opnd      <= '0;
         hi_w      <= '0;
         lo_w      <= '0;
         md_busy   <= 1'b0;
         md_done   <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         md_done <= 1'b0;
         if (md_flush) begin
            state   <= ST_IDLE;
            md_busy <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (md_valid) begin
                     case (md_op)
                        OP_MTHI: hi <= md_src_a;
                        OP_MTLO: lo <= md_src_a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                           a_raw     <= md_src_a;
                           b_raw     <= md_src_b;
                           is_div    <= (md_op == OP_DIV) || (md_op == OP_DIVU);
                           is_signed <= (md_op == OP_MULT) || (md_op == OP_DIV);
                           state     <= ST_PREP;
                           md_busy   <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
               ST_PREP: begin
                  q_neg <= is_signed & (a_raw[31] ^ b_raw[31]);
                  r_neg <= is_signed & a_raw[31];
                  opnd  <= is_div ? abs_b : abs_a;
                  lo_w  <= is_div ? abs_a : abs_b;
                  hi_w  <= '0;
                  cnt   <= '0;
                  state <= ST_CALC;
               end
               ST_CALC: begin
                  hi_w <= step_hi;
                  lo_w <= step_lo;
                  cnt  <= cnt + 5'd1;
                  if (cnt == 5'(CALC_CYCLES - 1)) begin
                     state   <= ST_FIX;
                     md_done <= 1'b1;
                  end
               end
               ST_FIX: begin
                  if (is_div) begin
                     if (b_raw == '0) begin
                        lo <= '1;
                        hi <= a_raw;
                     end else begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                     end
                  end else begin
                     {hi, lo} <= prod_fix;
                  end
                  state   <= ST_IDLE;
                  md_busy <= 1'b0;
               end
               default: begin
                  state   <= ST_IDLE;
                  md_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
